// File: rtl/conv_tap_sequencer.sv
// Conv forward-pass MAC sequencer: walks outputs (ow,oh,oc) and taps (kw,kh,ic); first tap valid the cycle after start.
// Tap fields hold while tap_ready is low; one tap per cycle at full rate; each output waits for res_valid, then one out_we.
module conv_tap_sequencer #(
    parameter int IN_CHANNELS  = 2,
    parameter int OUT_CHANNELS = 1,
    parameter int IN_HEIGHT    = 4,
    parameter int IN_WIDTH     = 4,
    parameter int KERNEL_SIZE  = 2,
    parameter int STRIDE       = 2,
    parameter int PADDING      = 0,
    parameter int ADDR_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  tap_valid,
    input  logic                  tap_ready,
    output logic                  tap_first,
    output logic                  tap_last,
    output logic                  tap_pad,
    output logic [ADDR_WIDTH-1:0] in_addr,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [ADDR_WIDTH-1:0] bias_addr,
    input  logic                  res_valid,
    output logic                  out_we,
    output logic [ADDR_WIDTH-1:0] out_addr
);
    localparam int OUT_HEIGHT = (IN_HEIGHT + 2*PADDING - KERNEL_SIZE) / STRIDE + 1;
    localparam int OUT_WIDTH  = (IN_WIDTH  + 2*PADDING - KERNEL_SIZE) / STRIDE + 1;

    localparam int IC_W = (IN_CHANNELS  > 1) ? $clog2(IN_CHANNELS)  : 1;
    localparam int OC_W = (OUT_CHANNELS > 1) ? $clog2(OUT_CHANNELS) : 1;
    localparam int K_W  = (KERNEL_SIZE  > 1) ? $clog2(KERNEL_SIZE)  : 1;
    localparam int OH_W = (OUT_HEIGHT   > 1) ? $clog2(OUT_HEIGHT)   : 1;
    localparam int OW_W = (OUT_WIDTH    > 1) ? $clog2(OUT_WIDTH)    : 1;

    localparam logic [IC_W-1:0] IC_MAX = IC_W'(IN_CHANNELS - 1);
    localparam logic [OC_W-1:0] OC_MAX = OC_W'(OUT_CHANNELS - 1);
    localparam logic [K_W-1:0]  K_MAX  = K_W'(KERNEL_SIZE - 1);
    localparam logic [OH_W-1:0] OH_MAX = OH_W'(OUT_HEIGHT - 1);
    localparam logic [OW_W-1:0] OW_MAX = OW_W'(OUT_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_RES, WRITE, FINISH} state_t;

    typedef struct packed {
        logic                  first;
        logic                  last;
        logic                  pad;
        logic [ADDR_WIDTH-1:0] in_addr;
        logic [ADDR_WIDTH-1:0] w_addr;
    } tap_t;

    function automatic tap_t make_tap(int oc, int oh, int ow, int ic, int kh, int kw);
        tap_t t;
        int   ih;
        int   iw;
        ih        = oh*STRIDE + kh - PADDING;
        iw        = ow*STRIDE + kw - PADDING;
        t.first   = (ic == 0) && (kh == 0) && (kw == 0);
        t.last    = (ic == IN_CHANNELS-1) && (kh == KERNEL_SIZE-1) && (kw == KERNEL_SIZE-1);
        t.pad     = (ih < 0) || (ih >= IN_HEIGHT) || (iw < 0) || (iw >= IN_WIDTH);
        t.in_addr = t.pad ? '0 : ADDR_WIDTH'(ic*IN_HEIGHT*IN_WIDTH + ih*IN_WIDTH + iw);
        t.w_addr  = ADDR_WIDTH'(((oc*IN_CHANNELS + ic)*KERNEL_SIZE + kh)*KERNEL_SIZE + kw);
        return t;
    endfunction

    state_t          state;
    tap_t            tap_q;
    logic [IC_W-1:0] ic;
    logic [K_W-1:0]  kh, kw;
    logic [OC_W-1:0] oc;
    logic [OH_W-1:0] oh;
    logic [OW_W-1:0] ow;

    logic [IC_W-1:0] nic;
    logic [K_W-1:0]  nkh, nkw;
    logic [OC_W-1:0] noc;
    logic [OH_W-1:0] noh;
    logic [OW_W-1:0] now_pos;
    logic            tap_end, pos_end;
    tap_t            tap_adv, tap_pos, tap_zero;
    logic [ADDR_WIDTH-1:0] out_cur;

    // Next tap within the current output and next output position are both
    // precomputed so the registered tap fields update with no bubble.
    always_comb begin
        tap_end = (ic == IC_MAX) && (kh == K_MAX) && (kw == K_MAX);
        nkw     = (kw == K_MAX) ? '0 : kw + 1'b1;
        nkh     = (kw == K_MAX) ? ((kh == K_MAX) ? '0 : kh + 1'b1) : kh;
        nic     = ((kw == K_MAX) && (kh == K_MAX)) ? ic + 1'b1 : ic;

        pos_end = (oc == OC_MAX) && (oh == OH_MAX) && (ow == OW_MAX);
        now_pos = (ow == OW_MAX) ? '0 : ow + 1'b1;
        noh     = (ow == OW_MAX) ? ((oh == OH_MAX) ? '0 : oh + 1'b1) : oh;
        noc     = ((ow == OW_MAX) && (oh == OH_MAX)) ? oc + 1'b1 : oc;

        tap_adv  = make_tap(int'(oc), int'(oh), int'(ow), int'(nic), int'(nkh), int'(nkw));
        tap_pos  = make_tap(int'(noc), int'(noh), int'(now_pos), 0, 0, 0);
        tap_zero = make_tap(0, 0, 0, 0, 0, 0);
        out_cur  = ADDR_WIDTH'(int'(oc)*OUT_HEIGHT*OUT_WIDTH + int'(oh)*OUT_WIDTH + int'(ow));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tap_q     <= '0;
            ic        <= '0;
            kh        <= '0;
            kw        <= '0;
            oc        <= '0;
            oh        <= '0;
            ow        <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            tap_valid <= 1'b0;
            bias_addr <= '0;
            out_we    <= 1'b0;
            out_addr  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= ISSUE;
                        busy      <= 1'b1;
                        tap_valid <= 1'b1;
                        tap_q     <= tap_zero;
                        bias_addr <= '0;
                    end
                end
                ISSUE: begin
                    if (tap_ready) begin
                        if (tap_end) begin
                            state     <= WAIT_RES;
                            tap_valid <= 1'b0;
                            tap_q     <= '0;
                            ic        <= '0;
                            kh        <= '0;
                            kw        <= '0;
                        end else begin
                            tap_q <= tap_adv;
                            ic    <= nic;
                            kh    <= nkh;
                            kw    <= nkw;
                        end
                    end
                end
                WAIT_RES: begin
                    if (res_valid) begin
                        state    <= WRITE;
                        out_we   <= 1'b1;
                        out_addr <= out_cur;
                    end
                end
                WRITE: begin
                    out_we   <= 1'b0;
                    out_addr <= '0;
                    if (pos_end) begin
                        state     <= FINISH;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        bias_addr <= '0;
                        oc        <= '0;
                        oh        <= '0;
                        ow        <= '0;
                    end else begin
                        state     <= ISSUE;
                        tap_valid <= 1'b1;
                        tap_q     <= tap_pos;
                        bias_addr <= ADDR_WIDTH'(noc);
                        oc        <= noc;
                        oh        <= noh;
                        ow        <= now_pos;
                    end
                end
                FINISH: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign tap_first = tap_q.first;
    assign tap_last  = tap_q.last;
    assign tap_pad   = tap_q.pad;
    assign in_addr   = tap_q.in_addr;
    assign w_addr    = tap_q.w_addr;

endmodule

// File: tb/tb_conv_tap_sequencer.sv
// Bench for conv_tap_sequencer: three configurations side by side, table-driven passes
// checked against a loop-nest reference model, plus reset and start-while-busy sequences.
module tb_conv_tap_sequencer;

    logic clk;
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic        rst [3];
    logic        start [3];
    logic        tap_ready [3];
    logic        res_valid [3];
    logic        busy [3];
    logic        done [3];
    logic        tap_valid [3];
    logic        tap_first [3];
    logic        tap_last [3];
    logic        tap_pad [3];
    logic        out_we [3];
    logic [15:0] in_addr [3];
    logic [15:0] w_addr [3];
    logic [15:0] bias_addr [3];
    logic [15:0] out_addr [3];

    // 0: defaults, 1: IC=1 K=3 S=1 P=1, 2: OC=2
    for (genvar g = 0; g < 3; g++) begin : g_dut
        conv_tap_sequencer #(
            .IN_CHANNELS  (g == 1 ? 1 : 2),
            .OUT_CHANNELS (g == 2 ? 2 : 1),
            .IN_HEIGHT    (4),
            .IN_WIDTH     (4),
            .KERNEL_SIZE  (g == 1 ? 3 : 2),
            .STRIDE       (g == 1 ? 1 : 2),
            .PADDING      (g == 1 ? 1 : 0),
            .ADDR_WIDTH   (16)
        ) u_dut (
            .clk       (clk),
            .rst       (rst[g]),
            .start     (start[g]),
            .busy      (busy[g]),
            .done      (done[g]),
            .tap_valid (tap_valid[g]),
            .tap_ready (tap_ready[g]),
            .tap_first (tap_first[g]),
            .tap_last  (tap_last[g]),
            .tap_pad   (tap_pad[g]),
            .in_addr   (in_addr[g]),
            .w_addr    (w_addr[g]),
            .bias_addr (bias_addr[g]),
            .res_valid (res_valid[g]),
            .out_we    (out_we[g]),
            .out_addr  (out_addr[g])
        );
    end

    int c_ic [3] = '{2, 1, 2};
    int c_oc [3] = '{1, 1, 2};
    int c_k  [3] = '{2, 3, 2};
    int c_s  [3] = '{2, 1, 2};
    int c_p  [3] = '{0, 1, 0};

    typedef struct packed {
        logic [1:0]  inst;
        logic        first;
        logic        last;
        logic        pad;
        logic [15:0] in_addr;
        logic [15:0] w_addr;
        logic [15:0] bias;
    } tap_rec_t;

    typedef struct packed {
        logic [1:0]  inst;
        logic [15:0] addr;
    } out_rec_t;

    tap_rec_t tap_log [$];
    out_rec_t out_log [$];
    int       done_cnt [3];
    int       stall_checks;
    int       stall_viol;
    int       ready_mode [3];
    int       res_cnt [3];

    // Monitor: logs transfers, writes and done pulses; tracks tap-field stability while stalled.
    initial begin
        tap_rec_t held [3];
        logic     prev_stall [3];
        tap_rec_t cur;
        stall_checks = 0;
        stall_viol   = 0;
        for (int i = 0; i < 3; i++) begin
            done_cnt[i]   = 0;
            prev_stall[i] = 1'b0;
            held[i]       = '0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                cur = '{inst: 2'(i), first: tap_first[i], last: tap_last[i], pad: tap_pad[i],
                        in_addr: in_addr[i], w_addr: w_addr[i], bias: bias_addr[i]};
                if (prev_stall[i]) begin
                    stall_checks++;
                    if (cur !== held[i] || tap_valid[i] !== 1'b1) stall_viol++;
                end
                prev_stall[i] = tap_valid[i] && !tap_ready[i];
                held[i]       = cur;
                if (tap_valid[i] && tap_ready[i]) tap_log.push_back(cur);
                if (out_we[i]) out_log.push_back('{inst: 2'(i), addr: out_addr[i]});
                if (done[i]) done_cnt[i]++;
            end
        end
    end

    // MAC responder: tap_ready pattern per mode, res_valid some cycles after the last tap.
    initial begin
        for (int i = 0; i < 3; i++) begin
            tap_ready[i] = 1'b0;
            res_valid[i] = 1'b0;
            res_cnt[i]   = 0;
            ready_mode[i] = 0;
        end
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                res_valid[i] = 1'b0;
                if (res_cnt[i] > 0) begin
                    res_cnt[i]--;
                    if (res_cnt[i] == 0) res_valid[i] = 1'b1;
                end else if (ready_mode[i] == 2 && tap_valid[i]) begin
                    res_valid[i] = ($urandom_range(0, 3) == 0);
                end
                case (ready_mode[i])
                    1:       tap_ready[i] = !tap_ready[i];
                    2:       tap_ready[i] = 1'($urandom_range(0, 1));
                    default: tap_ready[i] = 1'b1;
                endcase
                if (tap_valid[i] && tap_ready[i] && tap_last[i])
                    res_cnt[i] = (ready_mode[i] == 2) ? int'($urandom_range(1, 4)) : 2;
            end
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    tap_rec_t    exp_taps [$];
    logic [15:0] exp_outs [$];

    // Reference: plain loop nest over outputs and taps in the required order.
    task automatic build_model(input int g);
        int       on;
        int       ih;
        int       iw;
        tap_rec_t r;
        exp_taps.delete();
        exp_outs.delete();
        on = (4 + 2*c_p[g] - c_k[g]) / c_s[g] + 1;
        for (int oc = 0; oc < c_oc[g]; oc++)
            for (int oh = 0; oh < on; oh++)
                for (int ow = 0; ow < on; ow++) begin
                    exp_outs.push_back(16'(oc*on*on + oh*on + ow));
                    for (int ic = 0; ic < c_ic[g]; ic++)
                        for (int kh = 0; kh < c_k[g]; kh++)
                            for (int kw = 0; kw < c_k[g]; kw++) begin
                                ih        = oh*c_s[g] + kh - c_p[g];
                                iw        = ow*c_s[g] + kw - c_p[g];
                                r.inst    = 2'(g);
                                r.first   = (ic == 0 && kh == 0 && kw == 0);
                                r.last    = (ic == c_ic[g]-1 && kh == c_k[g]-1 && kw == c_k[g]-1);
                                r.pad     = (ih < 0 || ih >= 4 || iw < 0 || iw >= 4);
                                r.in_addr = r.pad ? 16'd0 : 16'(ic*16 + ih*4 + iw);
                                r.w_addr  = 16'(((oc*c_ic[g] + ic)*c_k[g] + kh)*c_k[g] + kw);
                                r.bias    = 16'(oc);
                                exp_taps.push_back(r);
                            end
                end
    endtask

    task automatic run_pass(input int g, output int tbase, output int obase);
        int dbase;
        bit seen;
        tbase = tap_log.size();
        obase = out_log.size();
        dbase = done_cnt[g];
        @(negedge clk);
        start[g] = 1'b1;
        @(negedge clk);
        start[g] = 1'b0;
        check("busy_after_start", 64'(busy[g]), 64'(1));
        seen = 1'b0;
        for (int c = 0; c < 4000 && !seen; c++) begin
            @(negedge clk);
            if (done[g]) begin
                seen = 1'b1;
                check("busy_low_at_done", 64'(busy[g]), 64'(0));
            end
        end
        check("pass_completed", 64'(seen), 64'(1));
        repeat (5) @(negedge clk);
        check("done_pulses", 64'(done_cnt[g] - dbase), 64'(1));
    endtask

    task automatic check_idle(input int g);
        check("idle_flags", 64'({busy[g], done[g], tap_valid[g], tap_first[g], tap_last[g],
                                 tap_pad[g], out_we[g]}), 64'(0));
        check("idle_addrs", 64'({in_addr[g], w_addr[g], bias_addr[g], out_addr[g]}), 64'(0));
    endtask

    typedef struct {
        int inst;
        int mode;
        int n_outs;
        int n_taps;
        int n_first;
        int n_last;
    } vec_t;

    initial begin
        vec_t vecs [6];
        int   exp_in0 [8];
        int   tb, ob, ntap, nout, nf, nl, mism, omism, sc0, sv0, d0, g, cnt;
        bit   found;
        logic [8:0] padmask;

        vecs[0] = '{0, 0, 4, 32, 4, 4};
        vecs[1] = '{0, 1, 4, 32, 4, 4};
        vecs[2] = '{1, 0, 16, 144, 16, 16};
        vecs[3] = '{2, 0, 8, 64, 8, 8};
        vecs[4] = '{0, 2, 4, 32, 4, 4};
        vecs[5] = '{1, 2, 16, 144, 16, 16};
        exp_in0 = '{0, 1, 4, 5, 16, 17, 20, 21};

        for (int i = 0; i < 3; i++) begin
            rst[i]   = 1'b1;
            start[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) check_idle(i);
        for (int i = 0; i < 3; i++) rst[i] = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            g = vecs[v].inst;
            ready_mode[g] = vecs[v].mode;
            build_model(g);
            sc0 = stall_checks;
            sv0 = stall_viol;
            run_pass(g, tb, ob);
            ready_mode[g] = 0;
            ntap = tap_log.size() - tb;
            nout = out_log.size() - ob;
            check("tap_count", 64'(ntap), 64'(vecs[v].n_taps));
            check("out_count", 64'(nout), 64'(vecs[v].n_outs));
            nf = 0; nl = 0; mism = 0; omism = 0;
            for (int i = 0; i < ntap; i++) begin
                if (tap_log[tb+i].first) nf++;
                if (tap_log[tb+i].last) nl++;
                if (i >= exp_taps.size() || tap_log[tb+i] !== exp_taps[i]) mism++;
            end
            for (int i = 0; i < nout; i++)
                if (i >= exp_outs.size() || out_log[ob+i].addr !== exp_outs[i]) omism++;
            check("first_count", 64'(nf), 64'(vecs[v].n_first));
            check("last_count", 64'(nl), 64'(vecs[v].n_last));
            check("tap_seq_mismatches", 64'(mism), 64'(0));
            check("out_seq_mismatches", 64'(omism), 64'(0));
            check("stall_hold_violations", 64'(stall_viol - sv0), 64'(0));
            if (vecs[v].mode == 1) check("stall_cycles_seen", 64'(stall_checks > sc0), 64'(1));

            if (ntap == vecs[v].n_taps) begin
                if (v == 0) begin
                    for (int i = 0; i < 8; i++) begin
                        check("out0_in_addr", 64'(tap_log[tb+i].in_addr), 64'(exp_in0[i]));
                        check("out0_w_addr", 64'(tap_log[tb+i].w_addr), 64'(i));
                    end
                    check("out3_first_in_addr", 64'(tap_log[tb+24].in_addr), 64'(10));
                end
                if (v == 2) begin
                    padmask = '0;
                    for (int i = 0; i < 9; i++) padmask[i] = tap_log[tb+i].pad;
                    check("out0_pad_mask", 64'(padmask), 64'(9'h04F));
                    check("out0_tap4_in_addr", 64'(tap_log[tb+4].in_addr), 64'(0));
                    check("out0_tap5_in_addr", 64'(tap_log[tb+5].in_addr), 64'(1));
                    cnt = 0;
                    for (int i = 45; i < 54; i++) if (tap_log[tb+i].pad) cnt++;
                    check("out5_pad_count", 64'(cnt), 64'(0));
                end
                if (v == 3) begin
                    check("oc1_bias_addr", 64'(tap_log[tb+32].bias), 64'(1));
                    check("oc1_first_w_addr", 64'(tap_log[tb+32].w_addr), 64'(8));
                    cnt = 0;
                    for (int i = 32; i < 64; i++) if (tap_log[tb+i].bias != 16'd1) cnt++;
                    check("oc1_bias_stable", 64'(cnt), 64'(0));
                end
            end
            repeat (3) @(negedge clk);
        end

        // Reset during ISSUE of output 2 aborts the pass silently.
        ob = out_log.size();
        d0 = done_cnt[0];
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 500 && !found; c++) begin
            @(negedge clk);
            if (out_log.size() - ob >= 2 && tap_valid[0]) found = 1'b1;
        end
        check("reached_output2_issue", 64'(found), 64'(1));
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        check_idle(0);
        repeat (20) @(negedge clk);
        check("no_done_after_abort", 64'(done_cnt[0] - d0), 64'(0));
        check("writes_before_abort", 64'(out_log.size() - ob), 64'(2));
        build_model(0);
        run_pass(0, tb, ob);
        check("rerun_out_count", 64'(out_log.size() - ob), 64'(4));
        if (out_log.size() > ob) check("rerun_first_out_addr", 64'(out_log[ob].addr), 64'(0));

        // start held high through the whole pass, including the done cycle.
        ob = out_log.size();
        d0 = done_cnt[0];
        @(negedge clk);
        start[0] = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 500 && !found; c++) begin
            @(negedge clk);
            if (done[0]) found = 1'b1;
        end
        check("held_start_done_seen", 64'(found), 64'(1));
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        @(negedge clk);
        check("no_restart_busy", 64'(busy[0]), 64'(0));
        check("no_restart_tap_valid", 64'(tap_valid[0]), 64'(0));
        repeat (20) @(negedge clk);
        check("held_start_single_done", 64'(done_cnt[0] - d0), 64'(1));
        check("held_start_single_pass", 64'(out_log.size() - ob), 64'(4));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/conv_tap_sequencer.md
Name: conv_tap_sequencer

Overview:
Control FSM that drives a shared multiply-accumulate datapath for one convolution forward pass. It walks every output position and, for each one, every kernel tap. Per tap it issues input, weight and bias indices into the flat tensors already used by the conv forward-pass block. It then waits for the MAC result and issues an output write strobe. Input, weight and output index layouts match the conv forward-pass flat tensor layout, so the existing tensors are reused unchanged.

Parameters:
IN_CHANNELS   2   input channels
OUT_CHANNELS  1   output channels
IN_HEIGHT     4   input rows
IN_WIDTH      4   input columns
KERNEL_SIZE   2   square kernel side
STRIDE        2   stride in both dimensions
PADDING       0   zero padding on each border
ADDR_WIDTH    16  width of all index outputs
OUT_HEIGHT and OUT_WIDTH are localparams, each = (IN + 2*PADDING - KERNEL_SIZE)/STRIDE + 1.

Ports:
clk        in   1           rising-edge clock
rst        in   1           synchronous reset, active-high
start      in   1           begin a pass; sampled only in IDLE
busy       out  1           high from the cycle after start until done
done       out  1           one-cycle pulse when the pass completes
tap_valid  out  1           tap fields are valid
tap_ready  in   1           MAC accepts the tap
tap_first  out  1           first tap of the current output (MAC clears accumulator)
tap_last   out  1           last tap of the current output
tap_pad    out  1           tap falls in padding; MAC must use operand 0
in_addr    out  ADDR_WIDTH  ic*IN_HEIGHT*IN_WIDTH + ih*IN_WIDTH + iw; 0 when tap_pad
w_addr     out  ADDR_WIDTH  ((oc*IN_CHANNELS+ic)*KERNEL_SIZE+kh)*KERNEL_SIZE+kw
bias_addr  out  ADDR_WIDTH  oc
res_valid  in   1           MAC result for the current output is ready
out_we     out  1           one-cycle write strobe
out_addr   out  ADDR_WIDTH  oc*OUT_HEIGHT*OUT_WIDTH + oh*OUT_WIDTH + ow

Behaviour:
- Reset: all outputs 0, FSM in IDLE, all counters 0. Reset mid-pass aborts the pass; no done pulse is issued.
- States are IDLE, ISSUE, WAIT_RES, WRITE, FINISH.
- IDLE: start=1 moves to ISSUE. busy and tap_valid rise on the next cycle. Tap 0 fields are registered and valid in that same cycle.
- ISSUE: tap_valid=1. A tap transfers on tap_valid & tap_ready.
  - All tap_* and address outputs hold stable while tap_valid & !tap_ready.
  - Tap order: kw fastest, then kh, then ic.
  - With tap_ready held high, one tap transfers per cycle with no bubbles.
  - When the tap_last transfer completes, the FSM moves to WAIT_RES and tap_valid drops in the next cycle.
- tap_first=1 only when ic=kh=kw=0. tap_last=1 only when ic=IN_CHANNELS-1, kh=kw=KERNEL_SIZE-1.
- Padding: ih = oh*STRIDE + kh - PADDING and iw = ow*STRIDE + kw - PADDING, computed signed.
  - If ih<0, ih>=IN_HEIGHT, iw<0 or iw>=IN_WIDTH: tap_pad=1 and in_addr=0.
  - Padded taps are still issued and still need a handshake.
- WAIT_RES: outputs idle. res_valid moves to WRITE. res_valid outside WAIT_RES is ignored.
- WRITE: out_we=1 for exactly one cycle, with out_addr for the current (oc,oh,ow).
  - Output order: ow fastest, then oh, then oc.
  - If this was the final output, go to FINISH; otherwise advance the position and return to ISSUE on the next cycle.
- FINISH: done=1 for one cycle, busy drops in the same cycle, then IDLE.
- start while busy is ignored. start in the same cycle as done is ignored; a new start is accepted from IDLE on the next cycle.
- bias_addr = oc, stable throughout each output.
- Counters use minimal widths. Addresses are truncated to ADDR_WIDTH; the ADDR_WIDTH parameter must be sized so every address fits.

Test Plan:
- Defaults, tap_ready=1, res_valid asserted 2 cycles after tap_last. Required:
  - 4 out_we strobes at out_addr 0,1,2,3 and 32 tap transfers total.
  - Output 0 in_addr sequence: 0,1,4,5,16,17,20,21.
  - Output 0 w_addr sequence: 0..7.
  - Output 3 first in_addr = 10.
  - Exactly one done pulse.
- Defaults, tap_ready toggling 1010...:
  - Tap fields stay unchanged across every stalled cycle.
  - The same 32-tap sequence transfers.
  - tap_first/tap_last each pulse on 4 transfers.
- IN_CHANNELS=1, KERNEL_SIZE=3, STRIDE=1, PADDING=1, 4x4 input:
  - 16 outputs, 144 taps.
  - Output 0 has tap_pad on taps 0,1,2,3,6; tap 4 has in_addr 0 and tap 5 has in_addr 1.
  - Output 5 has no padded taps.
- OUT_CHANNELS=2: bias_addr=1 and w_addr starts at 8 for out_addr 4..7.
- rst asserted for one cycle during ISSUE of output 2:
  - All outputs 0 on the next cycle and no done pulse.
  - A following start reruns from out_addr 0.
- start pulsed while busy and held high during the done cycle: neither starts a second pass.
